// File: rtl/spi_slave_leds.sv
// SPI responder that oversamples SCLK/MOSI/SSB in the clk domain, latches received bytes onto
// an LED register and returns a locally supplied byte on MISO. All four CPOL/CPHA modes, either bit order.
module spi_slave_leds (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk_i,
  input  logic       mosi_i,
  input  logic       ssb_i,
  output logic       miso_o,
  output logic       miso_en_o,
  input  logic       cpol_i,
  input  logic       cpha_i,
  input  logic       dord_i,
  input  logic [7:0] tx_i,
  output logic [7:0] rx_o,
  output logic       rx_valid_o,
  output logic       abort_o,
  output logic       busy_o,
  output logic [7:0] leds
);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e      state_q, state_d;
  logic [2:0]  sclk_sync_q;
  logic [2:0]  ssb_sync_q;
  logic [1:0]  mosi_sync_q;
  logic [1:0]  settle_q;
  logic        armed_q;
  logic        cpol_q, cpha_q, dord_q;
  logic [7:0]  tx_sr_q;
  logic [7:0]  rx_sr_q;
  logic [2:0]  cnt_q;
  logic        miso_q;
  logic [7:0]  rx_q;
  logic [7:0]  leds_q;
  logic        rx_valid_q;
  logic        abort_q;

  logic        sclk_s, ssb_s, mosi_s;
  logic        sclk_edge, lead_edge, trail_edge;
  logic        active, frame_start, sample, shift, byte_done;
  logic [7:0]  rx_next;

  function automatic logic tx_first(input logic [7:0] b, input logic lsb_first);
    return lsb_first ? b[0] : b[7];
  endfunction

  function automatic logic [7:0] tx_advance(input logic [7:0] b, input logic lsb_first);
    return lsb_first ? {1'b0, b[7:1]} : {b[6:0], 1'b0};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= {3{cpol_i}};
      ssb_sync_q  <= 3'b111;
      mosi_sync_q <= 2'b00;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], sclk_i};
      ssb_sync_q  <= {ssb_sync_q[1:0], ssb_i};
      mosi_sync_q <= {mosi_sync_q[0], mosi_i};
    end
  end

  assign sclk_s = sclk_sync_q[1];
  assign ssb_s  = ssb_sync_q[1];
  assign mosi_s = mosi_sync_q[1];

  // A frame may only start after SSB has been seen high on real (post-reset) samples, so an SSB
  // already low at reset release is not mistaken for a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_q <= 2'd0;
      armed_q  <= 1'b0;
    end else begin
      if (settle_q != 2'd2) settle_q <= settle_q + 2'd1;
      if (settle_q == 2'd2 && ssb_s) armed_q <= 1'b1;
    end
  end

  assign active      = (state_q == StActive);
  assign frame_start = (state_q == StIdle) && armed_q && !ssb_s && ssb_sync_q[2];
  assign sclk_edge   = sclk_s ^ sclk_sync_q[2];
  assign lead_edge   = sclk_edge && (sclk_s != cpol_q);
  assign trail_edge  = sclk_edge && (sclk_s == cpol_q);
  assign sample      = active && (cpha_q ? trail_edge : lead_edge);
  assign shift       = active && (cpha_q ? lead_edge : trail_edge);
  assign byte_done   = sample && (cnt_q == 3'd7);
  assign rx_next     = dord_q ? {mosi_s, rx_sr_q[7:1]} : {rx_sr_q[6:0], mosi_s};

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (frame_start) state_d = StActive;
      StActive: if (ssb_s)       state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_o    = (state_q == StActive);
    miso_en_o = (state_q == StActive);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      dord_q     <= 1'b0;
      tx_sr_q    <= 8'h00;
      rx_sr_q    <= 8'h00;
      cnt_q      <= 3'd0;
      miso_q     <= 1'b0;
      rx_q       <= 8'h00;
      leds_q     <= 8'h00;
      rx_valid_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      abort_q    <= 1'b0;
      if (frame_start) begin
        cpol_q  <= cpol_i;
        cpha_q  <= cpha_i;
        dord_q  <= dord_i;
        cnt_q   <= 3'd0;
        // With cpha=0 the first bit must already be on the wire before the first edge.
        tx_sr_q <= cpha_i ? tx_i : tx_advance(tx_i, dord_i);
        miso_q  <= cpha_i ? 1'b0 : tx_first(tx_i, dord_i);
      end else if (active) begin
        if (sample) begin
          rx_sr_q <= rx_next;
          cnt_q   <= cnt_q + 3'd1;
          if (byte_done) begin
            rx_q       <= rx_next;
            leds_q     <= rx_next;
            rx_valid_q <= 1'b1;
            tx_sr_q    <= tx_i;
          end
        end
        if (shift) begin
          miso_q  <= tx_first(tx_sr_q, dord_q);
          tx_sr_q <= tx_advance(tx_sr_q, dord_q);
        end
        if (ssb_s) begin
          miso_q <= 1'b0;
          if (!byte_done && (cnt_q != 3'd0 || sample)) abort_q <= 1'b1;
        end
      end
    end
  end

  assign miso_o     = miso_q;
  assign rx_o       = rx_q;
  assign leds       = leds_q;
  assign rx_valid_o = rx_valid_q;
  assign abort_o    = abort_q;

endmodule

// File: tb/tb_spi_slave_leds.sv
// Bench for spi_slave_leds: a bit-level SPI master drives frames while a byte-level model predicts
// received bytes, strobe counts, abort pulses and the MISO bit expected at every master sample edge.
module tb_spi_slave_leds;

  localparam int H = 8;  // SCLK half period in clk cycles

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk_i, mosi_i, ssb_i;
  logic       miso_o, miso_en_o;
  logic       cpol_i, cpha_i, dord_i;
  logic [7:0] tx_i;
  logic [7:0] rx_o;
  logic       rx_valid_o, abort_o, busy_o;
  logic [7:0] leds;

  spi_slave_leds dut (
    .clk        (clk),
    .rst        (rst),
    .sclk_i     (sclk_i),
    .mosi_i     (mosi_i),
    .ssb_i      (ssb_i),
    .miso_o     (miso_o),
    .miso_en_o  (miso_en_o),
    .cpol_i     (cpol_i),
    .cpha_i     (cpha_i),
    .dord_i     (dord_i),
    .tx_i       (tx_i),
    .rx_o       (rx_o),
    .rx_valid_o (rx_valid_o),
    .abort_o    (abort_o),
    .busy_o     (busy_o),
    .leds       (leds)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  int         rv_cnt = 0;
  int         ab_cnt = 0;
  logic [7:0] got_q[$];
  logic [7:0] mo[4];
  logic [7:0] tx[4];
  logic [7:0] exp_rx;

  always @(negedge clk) begin
    if (rx_valid_o) begin
      rv_cnt <= rv_cnt + 1;
      got_q.push_back(rx_o);
    end
    if (abort_o) ab_cnt <= ab_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model: every complete byte of mo[] is received in order; partial last byte aborts;
  // bit i of byte k on MISO is tx[k] bit (dord ? i : 7-i).
  task automatic spi_frame(input bit cp, input bit ph, input bit dr, input int nbytes,
                           input int last_bits, input bit flip_cpol, input bit hold_low);
    int rv0, ab0, q0, nfull, bits;
    bit mb, eb;
    rv0 = rv_cnt; ab0 = ab_cnt; q0 = got_q.size(); nfull = 0;
    cpol_i = cp; cpha_i = ph; dord_i = dr; sclk_i = cp; tx_i = tx[0];
    clks(6);
    ssb_i = 1'b0;
    clks(8);
    check_val("busy_sel", busy_o, 1);
    check_val("miso_en_sel", miso_en_o, 1);
    for (int k = 0; k < nbytes; k++) begin
      bits = (k == nbytes - 1 && last_bits != 0) ? last_bits : 8;
      for (int i = 0; i < bits; i++) begin
        mb = dr ? mo[k][i] : mo[k][7-i];
        eb = dr ? tx[k][i] : tx[k][7-i];
        if (!ph) begin
          mosi_i = mb;
          clks(H);
          sclk_i = ~cp;
          check_val("miso_bit", miso_o, eb);
          clks(H);
          sclk_i = cp;
        end else begin
          sclk_i = ~cp;
          mosi_i = mb;
          clks(H);
          sclk_i = cp;
          check_val("miso_bit", miso_o, eb);
          clks(H);
        end
        if (i == 0 && k < 3) tx_i = tx[k+1];
        if (flip_cpol && k == 0 && i == 3) cpol_i = ~cp;
      end
      if (bits == 8) begin
        nfull++;
        exp_rx = mo[k];
      end
    end
    if (hold_low) return;
    clks(H);
    ssb_i = 1'b1;
    clks(8);
    check_val("busy_idle", busy_o, 0);
    check_val("miso_en_idle", miso_en_o, 0);
    check_val("miso_idle", miso_o, 0);
    check_val("rx_valid_count", rv_cnt - rv0, nfull);
    check_val("abort_count", ab_cnt - ab0, (last_bits != 0) ? 1 : 0);
    if (got_q.size() >= q0 + nfull)
      for (int j = 0; j < nfull; j++) check_val("rx_byte", got_q[q0+j], mo[j]);
    check_val("rx_o", rx_o, exp_rx);
    check_val("leds", leds, exp_rx);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ab0, rv0;
    bit cp, ph, dr;
    int nb, lb;
    rst = 1'b1; sclk_i = 1'b0; mosi_i = 1'b0; ssb_i = 1'b1;
    cpol_i = 1'b0; cpha_i = 1'b0; dord_i = 1'b0; tx_i = 8'h00;
    exp_rx = 8'h00;
    clks(4);
    rst = 1'b0;
    check_val("rst_miso", miso_o, 0);
    check_val("rst_miso_en", miso_en_o, 0);
    check_val("rst_rx", rx_o, 8'h00);
    check_val("rst_rx_valid", rx_valid_o, 0);
    check_val("rst_abort", abort_o, 0);
    check_val("rst_busy", busy_o, 0);
    check_val("rst_leds", leds, 8'h00);

    // Mode 0 MSB first
    mo[0] = 8'hA5; tx[0] = 8'h3C;
    spi_frame(0, 0, 0, 1, 0, 0, 0);

    // Mode 3 LSB first, two bytes
    mo[0] = 8'h12; mo[1] = 8'h34; tx[0] = 8'h81; tx[1] = 8'h42;
    spi_frame(1, 1, 1, 2, 0, 0, 0);

    // Modes 1 and 2
    mo[0] = 8'hF0; tx[0] = 8'h6B;
    spi_frame(0, 1, 0, 1, 0, 0, 0);
    mo[0] = 8'hF0; tx[0] = 8'hD2;
    spi_frame(1, 0, 0, 1, 0, 0, 0);

    // Abort after 5 bits, previous byte 0x55
    mo[0] = 8'h55; tx[0] = 8'h99;
    spi_frame(0, 0, 0, 1, 0, 0, 0);
    mo[0] = 8'hFF;
    spi_frame(0, 0, 0, 1, 5, 0, 0);
    mo[0] = 8'h0F; tx[0] = 8'hE1;
    spi_frame(0, 0, 0, 1, 0, 0, 0);

    // Reset at bit 4 mid-frame
    ab0 = ab_cnt;
    mo[0] = 8'hFF; tx[0] = 8'h5A;
    spi_frame(0, 0, 0, 1, 4, 0, 1);
    rst = 1'b1;
    clks(2);
    ssb_i = 1'b1; sclk_i = 1'b0;
    rst = 1'b0;
    exp_rx = 8'h00;
    check_val("midrst_rx", rx_o, 8'h00);
    check_val("midrst_leds", leds, 8'h00);
    check_val("midrst_miso_en", miso_en_o, 0);
    check_val("midrst_busy", busy_o, 0);
    check_val("midrst_miso", miso_o, 0);
    clks(8);
    check_val("midrst_no_abort", ab_cnt - ab0, 0);
    mo[0] = 8'hC3; tx[0] = 8'h17;
    spi_frame(0, 0, 0, 1, 0, 0, 0);

    // SCLK activity while deselected
    rv0 = rv_cnt;
    for (int i = 0; i < 12; i++) begin
      sclk_i = ~sclk_i;
      mosi_i = 1'($urandom_range(0, 1));
      clks(4);
    end
    check_val("idle_sclk_miso_en", miso_en_o, 0);
    check_val("idle_sclk_rx_valid", rv_cnt - rv0, 0);
    sclk_i = 1'b0;

    // cpol_i flips mid-frame; mode must stay as captured
    mo[0] = 8'h3E; mo[1] = 8'hB7; tx[0] = 8'h28; tx[1] = 8'hC5;
    spi_frame(1, 0, 1, 2, 0, 1, 0);

    // Randomised frames
    for (int f = 0; f < 10; f++) begin
      cp = 1'($urandom_range(0, 1));
      ph = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      nb = $urandom_range(1, 3);
      lb = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
      for (int k = 0; k < 4; k++) begin
        mo[k] = 8'($urandom);
        tx[k] = 8'($urandom);
      end
      spi_frame(cp, ph, dr, nb, lb, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
